// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Purpose:
//   Sequential instruction fetch front end. The block walks a byte program
//   counter through an instruction memory of MEM_BYTES bytes. Each fetched
//   {pc, instruction} pair goes into a small FIFO (the fetch queue). The queue
//   head is offered to decode over a valid/ready handshake. A redirect
//   (branch/jump) flushes the queue and reloads the pc. Running past the end of
//   memory parks the sequencer in HALT until a redirect restarts it.
//
// Parameters:
//   MEM_BYTES  instruction memory size in bytes. A fetch at pc is legal while
//              pc + 4 <= MEM_BYTES.
//   FQ_DEPTH   fetch queue entries. Must be a power of two and at least 2.
//
// Optional feature (macro FETCH_MISALIGN_TRAP_EN):
//   Defined     : a redirect whose target has redirect_pc[1:0] != 0 flushes the
//                 queue and enters a sticky FAULT state. In FAULT, fault is 1,
//                 nothing is fetched and later redirects are ignored. Only
//                 reset leaves FAULT.
//   Not defined : the redirect target is forced to word alignment, fault is
//                 tied to 0 and FAULT is never entered.
//
// Ports:
//   clk             in   1   sole clock; all state changes on the rising edge
//   reset           in   1   asynchronous, active-high reset
//   inst_address    out 64   fetch byte address (the pc register)
//   instruction     in  32   combinational memory read data for inst_address
//   redirect_valid  in   1   redirect request
//   redirect_pc     in  64   redirect target
//   out_valid       out  1   queue head is valid (count != 0)
//   out_ready       in   1   decode accepts the head this cycle
//   out_inst        out 32   instruction word at the queue head
//   out_pc          out 64   pc of the queue head
//   halted          out  1   end of program reached and queue drained
//   fault           out  1   misaligned redirect trap taken
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int unsigned MEM_BYTES = 88,
    parameter int unsigned FQ_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] inst_address,
    input  logic [31:0] instruction,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [63:0] out_pc,
    output logic        halted,
    output logic        fault
);

    localparam int unsigned PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    // The limit is one bit wider than the pc, so pc + 4 cannot wrap before
    // the comparison.
    localparam logic [64:0]      MEM_LIMIT = 65'(MEM_BYTES);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FQ_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // Returns 1 when a 4-byte fetch at addr lies fully inside memory.
    // The sum is computed in 65 bits, so it does not wrap.
    function automatic logic fits_in_mem(input logic [63:0] addr);
        logic [64:0] end_addr;
        end_addr = {1'b0, addr} + 65'd4;
        return (end_addr <= MEM_LIMIT);
    endfunction

    // Registers
    state_t              r_state;
    logic [63:0]         r_pc;
    logic [CNT_W-1:0]    r_count;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [31:0]         r_q_inst [FQ_DEPTH];
    logic [63:0]         r_q_pc   [FQ_DEPTH];

    // Combinational control
    state_t              w_state_nxt;
    logic [63:0]         w_pc_nxt;
    logic                w_push;
    logic                w_do_pop;
    logic                w_flush;
    logic                w_pop_hs;
    logic                w_redirect_ok;
    logic [63:0]         w_target;

    // A pop handshake counts only while the queue actually holds an entry.
    assign w_pop_hs      = (r_count != {CNT_W{1'b0}}) && out_ready;
    // FAULT ignores redirects. Outside FAULT, every redirect is acted on.
    assign w_redirect_ok = redirect_valid && (r_state != ST_FAULT);
    // Word-aligned form of the redirect target.
    assign w_target      = redirect_pc & ~64'd3;

    // Next-state and datapath control. A redirect overrides push and pop.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_push      = 1'b0;
        w_do_pop    = 1'b0;
        w_flush     = 1'b0;

        if (w_redirect_ok) begin
            // The flush also discards any head entry popped on this edge,
            // so that pop counts as consumed.
            w_flush = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redirect_pc[1:0] != 2'b00) begin
                w_state_nxt = ST_FAULT;
            end else begin
                w_pc_nxt    = w_target;
                w_state_nxt = fits_in_mem(w_target) ? ST_RUN : ST_HALT;
            end
`else
            w_pc_nxt    = w_target;
            w_state_nxt = fits_in_mem(w_target) ? ST_RUN : ST_HALT;
`endif
        end else begin
            w_do_pop = w_pop_hs;
            case (r_state)
                ST_RUN: begin
                    if (!fits_in_mem(r_pc)) begin
                        w_state_nxt = ST_HALT;
                    end else if ((r_count != DEPTH_C) || w_pop_hs) begin
                        w_push   = 1'b1;
                        w_pc_nxt = r_pc + 64'd4;
                    end else begin
                        w_push   = 1'b0;
                    end
                end
                ST_HALT: begin
                    w_state_nxt = ST_HALT;
                end
                ST_FAULT: begin
                    w_state_nxt = ST_FAULT;
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    // State and pc registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_pc    <= 64'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Fetch queue storage, pointers and occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count  <= {CNT_W{1'b0}};
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            for (int i = 0; i < int'(FQ_DEPTH); i++) begin
                r_q_inst[i] <= 32'd0;
                r_q_pc[i]   <= 64'd0;
            end
        end else if (w_flush) begin
            r_count  <= {CNT_W{1'b0}};
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
        end else begin
            if (w_push) begin
                r_q_inst[r_wr_ptr] <= instruction;
                r_q_pc[r_wr_ptr]   <= r_pc;
                // FQ_DEPTH is a power of two, so the pointer wraps naturally.
                r_wr_ptr           <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign inst_address = r_pc;
    assign out_valid    = (r_count != {CNT_W{1'b0}});
    assign out_inst     = r_q_inst[r_rd_ptr];
    assign out_pc       = r_q_pc[r_rd_ptr];
    assign halted       = (r_state == ST_HALT) && (r_count == {CNT_W{1'b0}});
`ifdef FETCH_MISALIGN_TRAP_EN
    assign fault        = (r_state == ST_FAULT);
`else
    assign fault        = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Testbench for fetch_sequencer. A stimulus process drives inputs on the
// falling edge of clk. After each rising edge it updates a reference model: an
// expected-entry queue plus a pc and halt/fault flags. A monitor process
// checks the DUT shortly after each falling edge. When a valid/ready handshake
// is visible, it pops the expected entry and compares it with the DUT output.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam int unsigned MEM_BYTES = 88;
    localparam int unsigned FQ_DEPTH  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] inst_address;
    logic [31:0] instruction;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [63:0] out_pc;
    logic        halted;
    logic        fault;

    fetch_sequencer #(.MEM_BYTES(MEM_BYTES), .FQ_DEPTH(FQ_DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .inst_address   (inst_address),
        .instruction    (instruction),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .halted         (halted),
        .fault          (fault)
    );

    // Memory model: the instruction word is derived from its own address.
    assign instruction = 32'hA000_0000 | inst_address[31:0];

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] m_pc      = 64'd0;
    bit          m_stopped = 1'b0;
    bit          m_fault   = 1'b0;

    int n_vec  = 0;
    int n_miss = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit in_mem(input logic [63:0] a);
        return (65'(a) + 65'd4) <= 65'(MEM_BYTES);
    endfunction

    task automatic model_clear();
        exp_q.delete();
        m_pc      = 64'd0;
        m_stopped = 1'b0;
        m_fault   = 1'b0;
    endtask

    // Reference behaviour of one rising edge. Entries popped on this edge
    // have already been removed by the monitor.
    task automatic model_step();
        logic [63:0] tgt;
        exp_t        e;
        if (reset) begin
            model_clear();
        end else if (m_fault) begin
            // sticky: nothing changes
        end else if (redirect_valid) begin
            exp_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
            if ((redirect_pc % 64'd4) != 64'd0) begin
                m_fault   = 1'b1;
                m_stopped = 1'b0;
            end else begin
                m_pc      = redirect_pc;
                m_stopped = !in_mem(redirect_pc);
            end
`else
            tgt       = redirect_pc - (redirect_pc % 64'd4);
            m_pc      = tgt;
            m_stopped = !in_mem(tgt);
`endif
        end else if (!m_stopped) begin
            if (!in_mem(m_pc)) begin
                m_stopped = 1'b1;
            end else if (exp_q.size() < FQ_DEPTH) begin
                e.pc   = m_pc;
                e.inst = 32'hA000_0000 | m_pc[31:0];
                exp_q.push_back(e);
                m_pc   = m_pc + 64'd4;
            end
        end
    endtask

    // Runs one clock cycle with the given inputs.
    task automatic cyc(input bit rst, input bit rv, input logic [63:0] rpc, input bit rdy);
        @(negedge clk);
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        if (rst) model_clear();
        @(posedge clk);
        #1;
        model_step();
    endtask

    // Asserts reset between clock edges and checks that it takes effect at once.
    task automatic async_reset();
        #2;
        chk("pre_reset_queue_full", 64'(exp_q.size()), 64'(FQ_DEPTH));
        reset = 1'b1;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_inst_address", inst_address, 64'd0);
        model_clear();
    endtask

    // Monitor / scoreboard: checks DUT state and consumes handshakes.
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        chk("inst_address", inst_address, m_pc);
        chk("halted", 64'(halted), 64'(m_stopped && !m_fault && exp_q.size() == 0));
        chk("fault", 64'(fault), 64'(m_fault));
        if (reset) begin
            chk("rst_out_pc", out_pc, 64'd0);
            chk("rst_out_inst", 64'(out_inst), 64'd0);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_pc", out_pc, e.pc);
                chk("out_inst", 64'(out_inst), 64'(e.inst));
            end
        end
    end

    initial begin
        int          r;
        logic [63:0] rpc;
        // Reset, then a free-running stream through the whole memory.
        repeat (3) cyc(1'b1, 1'b0, 64'd0, 1'b1);
        repeat (26) cyc(1'b0, 1'b0, 64'd0, 1'b1);
        // Backpressure: the queue fills and the pc parks at 8.
        cyc(1'b0, 1'b1, 64'd0, 1'b0);
        repeat (5) cyc(1'b0, 1'b0, 64'd0, 1'b0);
        repeat (6) cyc(1'b0, 1'b0, 64'd0, 1'b1);
        // Redirect while the queue holds 12 and 16, with a handshake on the same edge.
        cyc(1'b0, 1'b1, 64'd12, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 64'd0, 1'b0);
        cyc(1'b0, 1'b1, 64'd40, 1'b1);
        repeat (5) cyc(1'b0, 1'b0, 64'd0, 1'b1);
        // Bounds: a target at the end of memory halts; target 0 restarts.
        cyc(1'b0, 1'b1, 64'd88, 1'b1);
        repeat (2) cyc(1'b0, 1'b0, 64'd0, 1'b1);
        cyc(1'b0, 1'b1, 64'd0, 1'b1);
        repeat (4) cyc(1'b0, 1'b0, 64'd0, 1'b1);
        // A target whose +4 wraps in 64 bits must still halt.
        cyc(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
        repeat (2) cyc(1'b0, 1'b0, 64'd0, 1'b1);
        // Misaligned redirect, followed by an aligned one.
        cyc(1'b0, 1'b1, 64'd42, 1'b1);
        repeat (3) cyc(1'b0, 1'b0, 64'd0, 1'b1);
        cyc(1'b0, 1'b1, 64'd0, 1'b1);
        repeat (3) cyc(1'b0, 1'b0, 64'd0, 1'b1);
        // Asynchronous reset while the queue is full.
        cyc(1'b1, 1'b0, 64'd0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 64'd0, 1'b0);
        async_reset();
        cyc(1'b1, 1'b0, 64'd0, 1'b1);
        repeat (4) cyc(1'b0, 1'b0, 64'd0, 1'b1);
        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                6:       rpc = 64'd88;
                7:       rpc = 64'(4 * $urandom_range(22, 40));
                8:       rpc = 64'hFFFF_FFFF_FFFF_FFFC;
                9:       rpc = 64'(4 * $urandom_range(0, 21) + $urandom_range(1, 3));
                default: rpc = 64'(4 * $urandom_range(0, 21));
            endcase
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 11) == 0), rpc,
                ($urandom_range(0, 3) != 0));
        end
        @(negedge clk);
        #4;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
